// File: rtl/bch_dec_arbiter_pkg.sv
// bch_arb_pkg: state enum, tag width helper and default BCH(31,11,5) constants shared by bch_dec_arbiter
package bch_arb_pkg;
  localparam int N_DEF = 31;
  localparam int K_DEF = 11;
  localparam int T_DEF = 5;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  function automatic int tag_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bch_dec_arbiter_if.sv
// bch_dec_arbiter_if: requester (req_*, flush), decoder (dec_*) and response (rsp_*) signals; slave = arbiter, master = environment
interface bch_dec_arbiter_if #(
  parameter int N = bch_arb_pkg::N_DEF,
  parameter int K = bch_arb_pkg::K_DEF,
  parameter int NREQ = 2
);
  import bch_arb_pkg::*;
  localparam int IW = tag_w(NREQ);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*N-1:0] req_data;
  logic flush;
  logic dec_start;
  logic [N-1:0] dec_data;
  logic dec_ready;
  logic dec_vdout;
  logic [K-1:0] dec_dout;
  logic dec_fail;
  logic rsp_valid;
  logic [IW-1:0] rsp_id;
  logic [K-1:0] rsp_data;
  logic rsp_fail;
  modport slave (
    input req_valid, req_data, flush, dec_ready, dec_vdout, dec_dout, dec_fail,
    output req_ready, dec_start, dec_data, rsp_valid, rsp_id, rsp_data, rsp_fail
  );
  modport master (
    output req_valid, req_data, flush, dec_ready, dec_vdout, dec_dout, dec_fail,
    input req_ready, dec_start, dec_data, rsp_valid, rsp_id, rsp_data, rsp_fail
  );
endinterface

// File: rtl/bch_dec_arbiter_tag_fifo.sv
// bch_tag_fifo: W-bit tag FIFO, DEPTH power of 2; ports clk, reset (sync active-low), push/pop/wdata in, rdata/full/empty/count out
module bch_tag_fifo #(
  parameter int W = 1,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    wp_d = push ? wp_q + AW'(1) : wp_q;
    rp_d = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= wdata;
  assign rdata = mem_q[rp_q];
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/bch_dec_arbiter.sv
// bch_dec_arbiter: round-robin NREQ-to-1 BCH decoder arbiter; clk, reset (sync active-low), bus (slave), idle, err_orphan; BCH_DEC_ARBITER_STATS_EN adds stat_frames/stat_fails
module bch_dec_arbiter
  import bch_arb_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF,
  parameter int T = T_DEF,
  parameter int NREQ = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic reset,
  bch_dec_arbiter_if.slave bus,
  output logic idle,
  output logic err_orphan
`ifdef BCH_DEC_ARBITER_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_fails
`endif
);
  localparam int IW = tag_w(NREQ);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, rr_idx, gnt_idx, tag;
  logic gnt_any, grant_en, xfer, pop, full, empty;
  logic [CW-1:0] count, cnt_nx;
  logic [N-1:0] sel_cw, dec_data_q, dec_data_d;
  logic [K-1:0] rsp_data_q, rsp_data_d;
  logic [IW-1:0] rsp_id_q, rsp_id_d;
  logic dec_start_q, dec_start_d, rsp_valid_q, rsp_valid_d, rsp_fail_q, rsp_fail_d;
  logic err_q, err_d, idle_q, idle_d;
  always_comb begin
    rr_idx = ptr_q;
    gnt_idx = ptr_q;
    gnt_any = 1'b0;
    for (int o = NREQ; o >= 1; o--) begin
      rr_idx = IW'((int'(ptr_q) + o) % NREQ);
      if (bus.req_valid[rr_idx]) begin
        gnt_idx = rr_idx;
        gnt_any = 1'b1;
      end
    end
    sel_cw = '0;
    for (int i = 0; i < NREQ; i++) sel_cw = (gnt_idx == IW'(i)) ? bus.req_data[i*N +: N] : sel_cw;
  end
  assign pop = bus.dec_vdout & ~empty;
  assign grant_en = (state_q == RUN) & bus.dec_ready & ~bus.flush & (~full | pop);
  assign xfer = grant_en & gnt_any;
  assign bus.req_ready = xfer ? NREQ'(1) << gnt_idx : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = (|bus.req_valid && !bus.flush) ? RUN : IDLE;
      RUN: state_d = bus.flush ? DRAIN : (!(|bus.req_valid) && empty) ? IDLE : RUN;
      DRAIN: state_d = (empty && !bus.dec_vdout) ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
    ptr_d = xfer ? gnt_idx : ptr_q;
    dec_start_d = xfer;
    dec_data_d = xfer ? sel_cw : dec_data_q;
    rsp_valid_d = pop;
    rsp_id_d = pop ? tag : rsp_id_q;
    rsp_data_d = pop ? bus.dec_dout : rsp_data_q;
    rsp_fail_d = pop ? bus.dec_fail : rsp_fail_q;
    err_d = err_q | (bus.dec_vdout & empty);
    cnt_nx = count + CW'(xfer) - CW'(pop);
    idle_d = (state_d == IDLE) && (cnt_nx == '0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q <= IW'(NREQ - 1);
      dec_start_q <= 1'b0;
      dec_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      rsp_fail_q <= 1'b0;
      err_q <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      dec_start_q <= dec_start_d;
      dec_data_q <= dec_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_fail_q <= rsp_fail_d;
      err_q <= err_d;
      idle_q <= idle_d;
    end
  end
  bch_tag_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(xfer),
    .pop(pop),
    .wdata(gnt_idx),
    .rdata(tag),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.dec_start = dec_start_q;
  assign bus.dec_data = dec_data_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_fail = rsp_fail_q;
  assign idle = idle_q;
  assign err_orphan = err_q;
`ifdef BCH_DEC_ARBITER_STATS_EN
  logic [31:0] frames_q, frames_d, fails_q, fails_d;
  always_comb begin
    frames_d = frames_q + 32'(rsp_valid_q && frames_q != '1);
    fails_d = fails_q + 32'(rsp_valid_q && rsp_fail_q && fails_q != '1);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      frames_q <= '0;
      fails_q <= '0;
    end else begin
      frames_q <= frames_d;
      fails_q <= fails_d;
    end
  end
  assign stat_frames = frames_q;
  assign stat_fails = fails_q;
`endif
endmodule

// File: tb/tb_bch_dec_arbiter.sv
// tb_bch_dec_arbiter: scoreboard bench for bch_dec_arbiter with a behavioural decoder model
module tb_bch_dec_arbiter;
  import bch_arb_pkg::*;
  localparam int N = 31;
  localparam int K = 11;
  localparam int NREQ = 2;
  localparam int DEPTH = 4;
  localparam int LAT = 3;
  localparam int IW = tag_w(NREQ);
  typedef struct packed {
    logic [IW-1:0] id;
    logic [K-1:0] data;
    logic fail;
  } rsp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic idle, err_orphan;
`ifdef BCH_DEC_ARBITER_STATS_EN
  logic [31:0] stat_frames, stat_fails;
`endif
  bch_dec_arbiter_if #(.N(N), .K(K), .NREQ(NREQ)) bus();
  bch_dec_arbiter #(.N(N), .K(K), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .idle(idle),
    .err_orphan(err_orphan)
`ifdef BCH_DEC_ARBITER_STATS_EN
    ,
    .stat_frames(stat_frames),
    .stat_fails(stat_fails)
`endif
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_xfer = 0;
  int n_rsp = 0;
  logic [N-1:0] src_q [NREQ][$];
  logic [N-1:0] issue_q [$];
  rsp_t exp_q [$];
  logic [N-1:0] pipe_cw [$];
  int pipe_due [$];
  int gnt_log [$];
  logic [NREQ-1:0] en = '1;
  logic hold = 1'b0;
  logic allow_one = 1'b0;
  logic orphan = 1'b0;
  logic flush_v = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    rsp_t r;
    logic [N-1:0] cw;
    @(negedge clk);
    cyc++;
    if (bus.dec_start) begin
      if (issue_q.size() == 0) check("dec_start_unexpected", 1, 0);
      else check("dec_data", bus.dec_data, issue_q.pop_front());
      pipe_cw.push_back(bus.dec_data);
      pipe_due.push_back(cyc + LAT - 1);
    end
    if (bus.rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        r = exp_q.pop_front();
        check("rsp_id", bus.rsp_id, r.id);
        check("rsp_data", bus.rsp_data, r.data);
        check("rsp_fail", bus.rsp_fail, r.fail);
      end
    end
    bus.dec_vdout = 1'b0;
    bus.dec_dout = '0;
    bus.dec_fail = 1'b0;
    if (orphan) begin
      bus.dec_vdout = 1'b1;
      bus.dec_dout = K'($urandom);
      orphan = 1'b0;
    end else if (pipe_due.size() > 0 && pipe_due[0] <= cyc && (!hold || allow_one)) begin
      cw = pipe_cw.pop_front();
      void'(pipe_due.pop_front());
      bus.dec_vdout = 1'b1;
      bus.dec_dout = cw[K-1:0];
      bus.dec_fail = cw[N-1];
      allow_one = 1'b0;
    end
    bus.flush = flush_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i] = en[i] && src_q[i].size() > 0;
      bus.req_data[i*N +: N] = bus.req_valid[i] ? src_q[i][0] : '0;
    end
    #1;
    check("req_ready_onehot", 64'($countones(bus.req_ready) <= 1), 1);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        cw = src_q[i].pop_front();
        issue_q.push_back(cw);
        exp_q.push_back('{id: IW'(i), data: cw[K-1:0], fail: cw[N-1]});
        gnt_log.push_back(i);
        n_xfer++;
      end
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.flush = 1'b0;
    bus.dec_ready = 1'b1;
    bus.dec_vdout = 1'b0;
    bus.dec_dout = '0;
    bus.dec_fail = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    issue_q.delete();
    exp_q.delete();
    pipe_cw.delete();
    pipe_due.delete();
    gnt_log.delete();
    en = '1;
    hold = 1'b0;
    allow_one = 1'b0;
    orphan = 1'b0;
    flush_v = 1'b0;
    n_xfer = 0;
    n_rsp = 0;
    repeat (2) @(negedge clk);
    check("rst_idle", idle, 1);
    check("rst_dec_start", bus.dec_start, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_fail", bus.rsp_fail, 0);
    check("rst_err_orphan", err_orphan, 0);
    check("rst_req_ready", bus.req_ready, 0);
`ifdef BCH_DEC_ARBITER_STATS_EN
    check("rst_stat_frames", stat_frames, 0);
    check("rst_stat_fails", stat_fails, 0);
`endif
    reset = 1'b1;
  endtask
  task automatic load(input int r, input int n);
    for (int j = 0; j < n; j++) src_q[r].push_back(N'($urandom));
  endtask
  task automatic drain(input int want, input int max);
    int k = 0;
    while ((n_xfer < want || exp_q.size() > 0 || issue_q.size() > 0) && k < max) begin
      step();
      k++;
    end
    check("drain_timeout", 64'(k < max), 1);
  endtask
  initial begin
    int k;
    logic [N-1:0] cw;
    do_reset();
    // orphan decoder output: sticky error, no response
    orphan = 1'b1;
    repeat (4) step();
    check("orphan_err", err_orphan, 1);
    check("orphan_no_rsp", n_rsp, 0);
    check("orphan_idle", idle, 1);
    // round-robin with both requesters always valid
    do_reset();
    load(0, 4);
    load(1, 4);
    drain(8, 200);
    check("rr_xfers", n_xfer, 8);
    for (int i = 0; i < gnt_log.size(); i++) check($sformatf("rr_gnt%0d", i), gnt_log[i], i % 2);
    check("rr_rsps", n_rsp, 8);
    repeat (3) step();
    check("rr_idle", idle, 1);
    // decoder withholds output: FIFO fills at DEPTH, then grant at full with simultaneous pop
    do_reset();
    hold = 1'b1;
    load(0, 6);
    load(1, 6);
    repeat (12) step();
    check("full_xfers", n_xfer, DEPTH);
    check("full_no_grant", bus.req_ready, 0);
    allow_one = 1'b1;
    step();
    check("full_pop_grant", 64'(|bus.req_ready), 1);
    check("full_pop_xfers", n_xfer, DEPTH + 1);
    step();
    check("full_count", dut.u_fifo.count, DEPTH);
    hold = 1'b0;
    drain(12, 300);
    check("full_all_rsps", n_rsp, 12);
    // flush with three frames in flight
    do_reset();
    hold = 1'b1;
    load(0, 6);
    load(1, 6);
    k = 0;
    while (n_xfer < 3 && k < 50) begin
      step();
      k++;
    end
    check("flush_setup_timeout", 64'(k < 50), 1);
    flush_v = 1'b1;
    hold = 1'b0;
    repeat (30) step();
    check("flush_xfers", n_xfer, 3);
    check("flush_rsps", n_rsp, 3);
    check("flush_scoreboard_empty", exp_q.size(), 0);
    check("flush_idle", idle, 1);
`ifdef BCH_DEC_ARBITER_STATS_EN
    do_reset();
    en = 2'b01;
    for (int j = 0; j < 10; j++) begin
      cw = N'($urandom);
      cw[N-1] = (j == 0 || j == 4 || j == 7);
      src_q[0].push_back(cw);
    end
    drain(10, 300);
    repeat (2) step();
    check("stat_frames", stat_frames, 10);
    check("stat_fails", stat_fails, 3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
